// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Misalignment trapping is controlled by the DMEM_MISALIGN_TRAP_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
    localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
    localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] align_offset(input size_e size, input logic [1:0] off);
        logic [1:0] r;
        case (size)
            SZ_BYTE: r = off;
            SZ_HALF: r = {off[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/data shift and load extraction/extension.
// Operates on 32-bit words with four byte lanes.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    assign w_shamt  = {i_offset, 3'b000};
    assign w_rshift = i_rword >> w_shamt;
    assign o_wdata  = i_wdata << w_shamt;

    always_comb begin
        o_be    = LANE_MASK_WORD;
        o_rdata = i_rword;
        case (i_size)
            SZ_BYTE: begin
                o_be    = LANE_MASK_BYTE << i_offset;
                o_rdata = i_unsigned ? {24'b0, w_rshift[7:0]}
                                     : {{24{w_rshift[7]}}, w_rshift[7:0]};
            end
            SZ_HALF: begin
                o_be    = LANE_MASK_HALF << i_offset;
                o_rdata = i_unsigned ? {16'b0, w_rshift[15:0]}
                                     : {{16{w_rshift[15]}}, w_rshift[15:0]};
            end
            default: begin
                o_be    = LANE_MASK_WORD;
                o_rdata = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked fixed-latency data-memory responder with lane-extracted, extended load data.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned/reserved-size requests via rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          r_state;
    logic            r_write;
    logic [AW+1:0]   r_addr;
    logic [N-1:0]    r_wdata;
    size_e           r_size;
    logic            r_unsigned;
    logic [CW-1:0]   r_cnt;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [N-1:0]    r_rsp_rdata;
    logic            r_rsp_err;
    logic [N-1:0]    r_mem [DEPTH];

    logic [AW-1:0]   w_word_idx;
    size_e           w_lane_size;
    logic [1:0]      w_offset;
    logic            w_err;
    logic            w_commit;
    logic            w_wr_en;
    logic [3:0]      w_be;
    logic [N-1:0]    w_bitmask;
    logic [N-1:0]    w_st_data;
    logic [N-1:0]    w_ld_data;
    logic            w_unused_addr;

    // Address bits above the word index wrap and are deliberately ignored.
    assign w_unused_addr = ^req_addr[N-1:AW+2];

    assign w_word_idx  = r_addr[AW+1:2];
    assign w_lane_size = (r_size == SZ_RSVD) ? SZ_WORD : r_size;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_err    = is_misaligned(r_size, r_addr[1:0]);
    assign w_offset = r_addr[1:0];
`else
    assign w_err    = 1'b0;
    assign w_offset = align_offset(w_lane_size, r_addr[1:0]);
`endif

    assign w_commit = (r_state == StAccess) && (r_cnt == '0);
    assign w_wr_en  = w_commit && r_write && !w_err;

    dmem_lane_align u_lane_align (
        .i_size     (w_lane_size),
        .i_offset   (w_offset),
        .i_wdata    (r_wdata),
        .i_unsigned (r_unsigned),
        .i_rword    (r_mem[w_word_idx]),
        .o_be       (w_be),
        .o_wdata    (w_st_data),
        .o_rdata    (w_ld_data)
    );

    always_comb begin
        w_bitmask = '0;
        for (int b = 0; b < 4; b++) begin
            w_bitmask[8*b +: 8] = {8{w_be[b]}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_word_idx] <= (r_mem[w_word_idx] & ~w_bitmask) | (w_st_data & w_bitmask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid && r_req_ready) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr[AW+1:0];
                        r_wdata     <= req_wdata;
                        r_size      <= size_e'(req_size);
                        r_unsigned  <= req_unsigned;
                        r_cnt       <= CW'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= StAccess;
                    end
                end
                StAccess: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= (r_write || w_err) ? '0 : w_ld_data;
                        r_rsp_err   <= w_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
